// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcode constants,
// control-state encoding and a small decode helper.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_NOP  = 3'b111;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/proc_regfile.sv
// General register file: one write port, one bus read port and one debug
// read port. Indices at or above NREG read as zero and ignore writes.
module proc_regfile
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_r [NREG];

  // Register storage; an out-of-range write address matches no entry.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (we && (waddr == 3'(i))) begin
          regs_r[i] <= wdata;
        end
      end
    end
  end

  // Bus-side read port.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) begin
      if (raddr == 3'(i)) begin
        rdata = regs_r[i];
      end
    end
  end

  // Observation read port.
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dbg_sel == 3'(i)) begin
        dbg_data = regs_r[i];
      end
    end
  end

endmodule

// File: rtl/proc_multiciclo.sv
// Multicycle processor: control FSM, instruction register, ALU operand and
// result registers, nz flag and a multiplexed internal bus.
module proc_multiciclo
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREG   = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_r, next_state_s;
  logic [8:0]        ir_r;
  logic [DATA_W-1:0] a_r, g_r;
  logic              nz_r;

  logic [2:0]        op_s, rx_s, ry_s;
  logic [DATA_W-1:0] bus_s, alu_s, rdata_s;
  logic [2:0]        raddr_s;
  logic              rf_we_s, done_s, ld_ir_s, ld_a_s, ld_g_s;

  assign op_s = ir_r[8:6];
  assign rx_s = ir_r[5:3];
  assign ry_s = ir_r[2:0];

  proc_regfile #(
    .DATA_W(DATA_W),
    .NREG  (NREG)
  ) u_regfile (
    .clock   (clock),
    .resetn  (resetn),
    .we      (rf_we_s),
    .waddr   (rx_s),
    .wdata   (bus_s),
    .raddr   (raddr_s),
    .rdata   (rdata_s),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  // Control sequencing: bus source, load enables and next state per step.
  always_comb begin
    next_state_s = state_r;
    bus_s        = '0;
    done_s       = 1'b0;
    rf_we_s      = 1'b0;
    raddr_s      = ry_s;
    ld_ir_s      = 1'b0;
    ld_a_s       = 1'b0;
    ld_g_s       = 1'b0;
    case (state_r)
      T0: begin
        if (run) begin
          ld_ir_s      = 1'b1;
          next_state_s = T1;
        end else begin
          next_state_s = T0;
        end
      end
      T1: begin
        case (op_s)
          OP_MV: begin
            bus_s        = rdata_s;
            rf_we_s      = 1'b1;
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_MVI: begin
            bus_s        = din;
            rf_we_s      = 1'b1;
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_MVNZ: begin
            bus_s        = rdata_s;
            rf_we_s      = nz_r;
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_NOP: begin
            done_s       = 1'b1;
            next_state_s = T0;
          end
          default: begin
            raddr_s      = rx_s;
            bus_s        = rdata_s;
            ld_a_s       = 1'b1;
            next_state_s = T2;
          end
        endcase
      end
      T2: begin
        bus_s        = rdata_s;
        ld_g_s       = 1'b1;
        next_state_s = T3;
      end
      T3: begin
        bus_s        = g_r;
        rf_we_s      = 1'b1;
        done_s       = 1'b1;
        next_state_s = T0;
      end
      default: begin
        next_state_s = T0;
      end
    endcase
  end

  // ALU: second operand is whatever the bus carries during T2.
  always_comb begin
    case (op_s)
      OP_ADD:  alu_s = a_r + bus_s;
      OP_SUB:  alu_s = a_r - bus_s;
      OP_AND:  alu_s = a_r & bus_s;
      OP_OR:   alu_s = a_r | bus_s;
      default: alu_s = '0;
    endcase
  end

  // State, instruction and ALU registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= T0;
      ir_r    <= 9'd0;
      a_r     <= '0;
      g_r     <= '0;
      nz_r    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (ld_ir_s) begin
        ir_r <= din[8:0];
      end
      if (ld_a_s) begin
        a_r <= bus_s;
      end
      if (ld_g_s && is_alu(op_s)) begin
        g_r  <= alu_s;
        nz_r <= (alu_s != '0);
      end
    end
  end

  assign bus  = bus_s;
  assign done = done_s;

endmodule

// File: tb/tb_proc_multiciclo.sv
// Scoreboard bench for proc_multiciclo: the driver pushes the expected done
// cycle and bus value of every instruction, a monitor pops them on done.
module tb_proc_multiciclo;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [15:0] din;
  logic        done;
  logic [15:0] bus;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  proc_multiciclo #(.DATA_W(16), .NREG(8)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .din     (din),
    .done    (done),
    .bus     (bus),
    .dbg_sel (dbg_sel),
    .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          dcyc;
    logic [15:0] bus;
    bit          chk_bus;
    logic [2:0]  op;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m[8];
  bit          mnz;
  int          checks = 0;
  int          passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding instruction.
  always @(negedge clock) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL spurious_done: done high at cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("op%0d_done_cycle", e.op), cyc, e.dcyc);
        if (e.chk_bus) check($sformatf("op%0d_bus", e.op), bus, e.bus);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i] = 16'h0000;
    mnz = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                       input logic [15:0] imm, input int gap);
    exp_t        e;
    logic [15:0] x, y, res;
    int          len;
    for (int g = 0; g < gap; g++) begin
      @(negedge clock);
      run = 1'b0;
      din = 16'($urandom);
    end
    @(negedge clock);
    run = 1'b1;
    din = {7'($urandom), op, rx, ry};
    x = m[rx];
    y = m[ry];
    len = 2;
    e.chk_bus = 1'b1;
    e.op = op;
    case (op)
      3'd0: begin e.bus = y; m[rx] = y; end
      3'd1: begin e.bus = imm; m[rx] = imm; end
      3'd6: begin e.bus = y; if (mnz) m[rx] = y; end
      3'd7: begin e.bus = 16'h0000; e.chk_bus = 1'b0; end
      default: begin
        if (op == 3'd2) res = x + y;
        else if (op == 3'd3) res = x - y;
        else if (op == 3'd4) res = x & y;
        else res = x | y;
        m[rx] = res;
        mnz = (res != 16'h0000);
        e.bus = res;
        len = 4;
      end
    endcase
    e.dcyc = cyc + len - 1;
    q.push_back(e);
    @(posedge clock);
    for (int k = 1; k < len; k++) begin
      @(negedge clock);
      run = 1'($urandom);
      din = (op == 3'd1) ? imm : 16'($urandom);
      @(posedge clock);
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      run = 1'b0;
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s_R%0d", tag, i), dbg_data, m[i]);
    end
  endtask

  task automatic peek(input string name, input logic [2:0] r, input logic [15:0] exp);
    @(negedge clock);
    run = 1'b0;
    dbg_sel = r;
    #1;
    check(name, dbg_data, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    run = 1'b0;
    din = 16'h0000;
    dbg_sel = 3'd0;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_done", done, 1'b0);
    check("reset_bus", bus, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("reset_R%0d", i), dbg_data, 16'h0000);
    end
    @(negedge clock);
    resetn = 1'b1;

    // mvi R0,5 ; mvi R1,3 ; add R0,R1 back to back
    issue(3'd1, 3'd0, 3'd0, 16'd5, 0);
    issue(3'd1, 3'd1, 3'd0, 16'd3, 0);
    issue(3'd2, 3'd0, 3'd1, 16'd0, 0);
    peek("add_R0", 3'd0, 16'h0008);

    // sub R1,R0 then mvnz R2,R1
    issue(3'd3, 3'd1, 3'd0, 16'd0, 0);
    issue(3'd6, 3'd2, 3'd1, 16'd0, 0);
    peek("sub_R1", 3'd1, 16'hFFFB);
    peek("mvnz_R2", 3'd2, 16'hFFFB);

    // sub R0,R0 clears nz, so mvnz R3,R1 must not write
    issue(3'd3, 3'd0, 3'd0, 16'd0, 1);
    issue(3'd6, 3'd3, 3'd1, 16'd0, 0);
    peek("subself_R0", 3'd0, 16'h0000);
    peek("mvnz_R3", 3'd3, 16'h0000);

    // wrap-around add, nz observed through mvnz R7,R5
    issue(3'd1, 3'd4, 3'd0, 16'hFFFF, 0);
    issue(3'd1, 3'd5, 3'd0, 16'h0001, 0);
    issue(3'd2, 3'd4, 3'd5, 16'd0, 0);
    issue(3'd6, 3'd7, 3'd5, 16'd0, 0);
    peek("wrap_R4", 3'd4, 16'h0000);
    peek("wrap_R7", 3'd7, 16'h0000);
    sweep("directed");

    // randomized instruction stream
    for (int n = 0; n < 90; n++) begin
      logic [15:0] imm;
      case ($urandom_range(0, 3))
        0: imm = 16'h0000;
        1: imm = 16'hFFFF;
        default: imm = 16'($urandom);
      endcase
      issue(3'($urandom), 3'($urandom), 3'($urandom), imm, $urandom_range(0, 2));
      if (n % 30 == 29) sweep($sformatf("rand%0d", n));
    end

    // reset during T2 of an add aborts it with no done
    @(negedge clock);
    run = 1'b1;
    din = {7'd0, 3'd2, 3'd0, 3'd1};
    @(posedge clock);
    @(negedge clock);
    run = 1'b0;
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b0;
    model_reset();
    @(negedge clock);
    check("abort_done", done, 1'b0);
    check("abort_bus", bus, 16'h0000);
    resetn = 1'b1;
    sweep("abort");
    issue(3'd1, 3'd6, 3'd0, 16'd7, 0);
    peek("after_abort_R6", 3'd6, 16'h0007);
    sweep("final");

    repeat (4) @(negedge clock);
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
